// File: rtl/bus_rx_pkg.sv
// Shared constants, packet type and destination-field helper for the bus receive terminal.
package bus_rx_pkg;

  localparam int PCKG_SZ = 16;
  localparam int ID_W    = 8;
  localparam logic [ID_W-1:0] BDCST_ID = 8'hFF;

  typedef logic [PCKG_SZ-1:0] pkt_t;

  function automatic logic [ID_W-1:0] get_dest(pkt_t pkt);
    return pkt[PCKG_SZ-1 -: ID_W];
  endfunction

endpackage

// File: rtl/bus_rx_terminal_if.sv
// Bus delivery (push/D_push) and local consumer handshake (rx_pndng/rx_data/rx_pop) of one terminal.
interface bus_rx_terminal_if
  import bus_rx_pkg::*;
#(
  parameter int pckg_sz = PCKG_SZ
);
  logic               push;
  logic [pckg_sz-1:0] D_push;
  logic               rx_pndng;
  logic [pckg_sz-1:0] rx_data;
  logic               rx_pop;

  // master: the bus plus the local consumer; slave: the receive terminal
  modport master (output push, D_push, rx_pop, input  rx_pndng, rx_data);
  modport slave  (input  push, D_push, rx_pop, output rx_pndng, rx_data);
endinterface

// File: rtl/bus_rx_fifo_mem.sv
// depth x width register array, one synchronous write port and one asynchronous read port.
module bus_rx_fifo_mem #(
  parameter int depth = 8,
  parameter int width = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(depth)-1:0] waddr,
  input  logic [width-1:0]         wdata,
  input  logic [$clog2(depth)-1:0] raddr,
  output logic [width-1:0]         rdata
);

  logic [width-1:0] mem [depth];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/bus_rx_terminal.sv
// Receive terminal: accepts bus pushes into a FWFT FIFO and offers them through pending/pop.
// Optional destination filtering and misroute_cnt are enabled with BUS_RX_ID_CHECK_EN.
module bus_rx_terminal
  import bus_rx_pkg::*;
#(
  parameter int pckg_sz = PCKG_SZ,
  parameter int id_w    = ID_W,
  parameter int depth   = 8,
  parameter logic [id_w-1:0] drv_id   = '0,
  parameter logic [id_w-1:0] bdcst_id = BDCST_ID
) (
  input  logic                   clk,
  input  logic                   reset,
  bus_rx_terminal_if.slave       bus,
  output logic [$clog2(depth):0] rx_count,
  output logic                   rx_full,
  output logic                   ovf_flag,
  output logic [7:0]             drop_cnt
`ifdef BUS_RX_ID_CHECK_EN
  ,
  output logic [7:0]             misroute_cnt
`endif
);

  localparam int aw = $clog2(depth);
  localparam logic [aw:0] full_cnt = (aw+1)'(depth);

  logic [aw-1:0]      wr_ptr;
  logic [aw-1:0]      rd_ptr;
  logic               pndng_q;
  logic [pckg_sz-1:0] rd_data;
  logic [aw:0]        cnt_nxt;
  logic               id_match;
  logic               pass_id;
  logic               pop_ok;
  logic               accept;
  logic               drop;

  assign id_match = (bus.D_push[pckg_sz-1 -: id_w] == drv_id) ||
                    (bus.D_push[pckg_sz-1 -: id_w] == bdcst_id);

`ifdef BUS_RX_ID_CHECK_EN
  assign pass_id = id_match;
`else
  logic id_match_unused;
  assign id_match_unused = id_match;
  assign pass_id = 1'b1;
`endif

  // a pop in the same cycle frees the slot, so a full FIFO can still accept
  assign pop_ok = bus.rx_pop && pndng_q;
  assign accept = bus.push && pass_id && (!rx_full || pop_ok);
  assign drop   = bus.push && pass_id && rx_full && !pop_ok;

  always_comb begin
    cnt_nxt = rx_count;
    if (accept && !pop_ok)      cnt_nxt = rx_count + 1'b1;
    else if (!accept && pop_ok) cnt_nxt = rx_count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rx_count <= '0;
      rx_full  <= 1'b0;
      pndng_q  <= 1'b0;
      ovf_flag <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      rx_count <= cnt_nxt;
      rx_full  <= (cnt_nxt == full_cnt);
      pndng_q  <= (cnt_nxt != '0);
      if (drop) begin
        ovf_flag <= 1'b1;
        if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end

`ifdef BUS_RX_ID_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset)
      misroute_cnt <= '0;
    else if (bus.push && !id_match && misroute_cnt != 8'hFF)
      misroute_cnt <= misroute_cnt + 1'b1;
  end
`endif

  bus_rx_fifo_mem #(
    .depth (depth),
    .width (pckg_sz)
  ) u_mem (
    .clk   (clk),
    .we    (accept),
    .waddr (wr_ptr),
    .wdata (bus.D_push),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  // stale array contents are masked so an empty FIFO always shows zero
  assign bus.rx_pndng = pndng_q;
  assign bus.rx_data  = pndng_q ? rd_data : '0;

endmodule

// File: tb/tb_bus_rx_terminal.sv
// Directed-plus-random bench for bus_rx_terminal against a queue-based reference model.
// Build with BUS_RX_ID_CHECK_EN defined to exercise destination filtering (drv_id=2).
module tb_bus_rx_terminal;
  import bus_rx_pkg::*;

  localparam int DEPTH = 8;
`ifdef BUS_RX_ID_CHECK_EN
  localparam logic [7:0] DRV = 8'h02;
`else
  localparam logic [7:0] DRV = 8'h00;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] rx_count;
  logic       rx_full;
  logic       ovf_flag;
  logic [7:0] drop_cnt;
`ifdef BUS_RX_ID_CHECK_EN
  logic [7:0] misroute_cnt;
`endif

  bus_rx_terminal_if #(.pckg_sz(16)) bus ();

  bus_rx_terminal #(
    .pckg_sz (16),
    .id_w    (8),
    .depth   (DEPTH),
    .drv_id  (DRV),
    .bdcst_id(8'hFF)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus.slave),
    .rx_count (rx_count),
    .rx_full  (rx_full),
    .ovf_flag (ovf_flag),
    .drop_cnt (drop_cnt)
`ifdef BUS_RX_ID_CHECK_EN
    ,
    .misroute_cnt(misroute_cnt)
`endif
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   failures = 0;
  pkt_t q[$];
  bit   m_ovf;
  int   m_drop;
  int   m_mis;
  pkt_t last_popped;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic pkt_t rnd_pkt();
    pkt_t p;
    p = 16'($urandom);
`ifdef BUS_RX_ID_CHECK_EN
    p[15:8] = ($urandom_range(0, 1) == 0) ? DRV : 8'hFF;
`endif
    return p;
  endfunction

  task automatic model_update(input bit r, input bit p, input pkt_t d, input bit pp);
    bit pop_ok;
    bit pass;
    bit acc;
    if (r) begin
      q.delete();
      m_ovf = 0;
      m_drop = 0;
      m_mis = 0;
      return;
    end
    pop_ok = pp && (q.size() > 0);
    pass = 1'b1;
`ifdef BUS_RX_ID_CHECK_EN
    pass = (get_dest(d) == DRV) || (get_dest(d) == BDCST_ID);
    if (p && !pass && m_mis < 255) m_mis++;
`endif
    acc = 1'b0;
    if (p && pass) begin
      if (q.size() < DEPTH || pop_ok) acc = 1'b1;
      else begin
        m_ovf = 1'b1;
        if (m_drop < 255) m_drop++;
      end
    end
    if (pop_ok) last_popped = q.pop_front();
    if (acc) q.push_back(d);
  endtask

  task automatic check_all();
    chk("rx_count", 32'(rx_count), 32'(q.size()));
    chk("rx_pndng", 32'(bus.rx_pndng), 32'(q.size() != 0));
    chk("rx_full", 32'(rx_full), 32'(q.size() == DEPTH));
    chk("rx_data", 32'(bus.rx_data), 32'((q.size() != 0) ? q[0] : 16'h0000));
    chk("ovf_flag", 32'(ovf_flag), 32'(m_ovf));
    chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
`ifdef BUS_RX_ID_CHECK_EN
    chk("misroute_cnt", 32'(misroute_cnt), 32'(m_mis));
`endif
  endtask

  task automatic step(input bit r, input bit p, input pkt_t d, input bit pp);
    @(negedge clk);
    reset = r;
    bus.push = p;
    bus.D_push = d;
    bus.rx_pop = pp;
    @(posedge clk);
    model_update(r, p, d, pp);
    #1;
    check_all();
  endtask

  initial begin
    pkt_t d;
    pkt_t bb;
    bus.push = 1'b0;
    bus.D_push = '0;
    bus.rx_pop = 1'b0;

    // reset held with a push pending: nothing may be stored
    for (int i = 0; i < 5; i++) step(1, 1, 16'h00AA, 0);
    step(0, 0, 16'h0000, 0);

    // ordering
    step(0, 1, {DRV, 8'h11}, 0);
    step(0, 1, {DRV, 8'h22}, 0);
    step(0, 1, {DRV, 8'h33}, 0);
    chk("ord_count3", 32'(rx_count), 32'd3);
    chk("ord_head", 32'(bus.rx_data), 32'({DRV, 8'h11}));
    step(0, 0, 16'h0000, 1);
    chk("ord_second", 32'(bus.rx_data), 32'({DRV, 8'h22}));
    step(0, 0, 16'h0000, 1);
    step(0, 0, 16'h0000, 1);
    chk("ord_empty", 32'(bus.rx_pndng), 32'd0);
    step(0, 0, 16'h0000, 1);

    // overflow: 10 pushes into 8 slots
    for (int i = 0; i < 10; i++) step(0, 1, rnd_pkt(), 0);
    chk("ovf_full", 32'(rx_full), 32'd1);
    chk("ovf_count", 32'(rx_count), 32'd8);
    chk("ovf_drop2", 32'(drop_cnt), 32'd2);
    for (int i = 0; i < 8; i++) step(0, 0, 16'h0000, 1);

    // full with simultaneous push and pop
    for (int i = 0; i < 8; i++) step(0, 1, rnd_pkt(), 0);
    bb = {DRV, 8'hBB};
    step(0, 1, bb, 1);
    chk("fullpp_count", 32'(rx_count), 32'd8);
    chk("fullpp_drop", 32'(drop_cnt), 32'd2);
    for (int i = 0; i < 8; i++) step(0, 0, 16'h0000, 1);
    chk("fullpp_last", 32'(last_popped), 32'(bb));

    // wrap-around through interleaved push/pop pairs
    for (int i = 0; i < 20; i++) begin
      d = rnd_pkt();
      step(0, 1, d, 0);
      chk("wrap_data", 32'(bus.rx_data), 32'(d));
      chk("wrap_cnt_le1", 32'(rx_count <= 1), 32'd1);
      step(0, 0, 16'h0000, 1);
    end

    // empty with simultaneous push and pop
    step(0, 1, {DRV, 8'h5A}, 1);
    chk("empty_pp_count", 32'(rx_count), 32'd1);

    // reset mid-stream discards buffered data
    step(0, 1, rnd_pkt(), 0);
    step(1, 1, rnd_pkt(), 1);
    step(0, 0, 16'h0000, 1);

`ifdef BUS_RX_ID_CHECK_EN
    step(0, 1, 16'h0201, 0);
    step(0, 1, 16'h0302, 0);
    step(0, 1, 16'hFF03, 0);
    chk("id_mis", 32'(misroute_cnt), 32'd1);
    chk("id_count", 32'(rx_count), 32'd2);
    chk("id_head", 32'(bus.rx_data), 32'h0201);
    step(0, 0, 16'h0000, 1);
    chk("id_second", 32'(bus.rx_data), 32'hFF03);
    step(0, 0, 16'h0000, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
